// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR datapath.
// Holds the sequencer state encoding, default sizes and output saturation.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam int FIR_NTAPS = 16;
    localparam int FIR_DW    = 32;
    localparam int FIR_CW    = 16;
    localparam int FIR_SHIFT = 15;

    // Wide enough for any practical accumulator; callers truncate to dw bits.
    localparam int SAT_W = 128;

    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int                      dw,
        input int                      shift
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = acc >>> shift;
        hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
        lo = ~hi;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: NTAPS x DW registers, one write and one read port.
// Clears to zero so a fresh filter behaves as if prefilled with silence.
module fir_sample_ring #(
    parameter int NTAPS = 16,
    parameter int DW    = 32,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [NTAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Single-multiplier FIR: one sample in, NTAPS MAC cycles, one saturated
// output held until the consumer takes it.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = FIR_NTAPS,
    parameter int DW    = FIR_DW,
    parameter int CW    = FIR_CW,
    parameter int SHIFT = FIR_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [CW-1:0]            coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     busy
);

    localparam int AW   = $clog2(NTAPS);
    localparam int PW   = DW + CW;
    localparam int ACCW = DW + CW + AW;

    state_t state;
    state_t nxt;

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          k;
    logic [AW-1:0]          rd_idx;
    logic [DW-1:0]          ring_rd;
    logic signed [CW-1:0]   coef [NTAPS];
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_sum;
    logic                   take;
    logic                   last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign take      = (state == IDLE) && in_valid;
    assign last      = (k == AW'(NTAPS - 1));

    // Tap k pairs with the sample k steps older than the newest one.
    assign rd_idx  = wr_ptr - k;
    assign prod    = PW'(coef[k]) * PW'($signed(ring_rd));
    assign acc_sum = acc + ACCW'(prod);

    fir_sample_ring #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .AW    (AW)
    ) u_ring (
        .clk     (clk),
        .rst_n   (reset),
        .we      (take),
        .wr_idx  (wr_ptr),
        .wr_data (in_data),
        .rd_idx  (rd_idx),
        .rd_data (ring_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  nxt = MAC;
            MAC:     if (last)      nxt = OUT;
            OUT:     if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    k   <= k + AW'(1);
                    if (last) begin
                        out_data <= DW'(sat_shift(SAT_W'(acc_sum), DW, SHIFT));
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Writes outside IDLE would corrupt a computation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef[i] <= '0;
            end
        end else if ((state == IDLE) && coef_we) begin
            coef[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed and randomized bench for fir_mac_sequencer against an
// arithmetic reference filter (dot product over a sample history).
module tb_fir_mac_sequencer;

    localparam int NTAPS = 16;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    fir_mac_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int fails   = 0;

    // hist[0] is the newest sample; h[k] the coefficient for tap k.
    longint hist [NTAPS];
    longint h    [NTAPS];

    function automatic void model_clear();
        for (int i = 0; i < NTAPS; i++) begin
            hist[i] = 0;
            h[i]    = 0;
        end
    endfunction

    function automatic void model_push(input logic signed [DW-1:0] x);
        for (int i = NTAPS - 1; i > 0; i--) begin
            hist[i] = hist[i-1];
        end
        hist[0] = longint'(x);
    endfunction

    function automatic longint model_y();
        longint s;
        s = 0;
        for (int i = 0; i < NTAPS; i++) begin
            s += h[i] * hist[i];
        end
        s = s >>> 15;
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    task automatic check(input string tag,
                         input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wcoef(input int a, input logic signed [CW-1:0] d);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
        h[a] = longint'(d);
    endtask

    // One full transaction; entered and left at a negedge with DUT in IDLE.
    task automatic run_sample(input logic signed [DW-1:0] x,
                              input int hold,
                              input bit we_now,
                              input bit we_mid,
                              input int wa,
                              input logic signed [CW-1:0] wd,
                              output longint y);
        longint exp;
        int lat;
        logic [DW-1:0] held;
        y = 0;
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = x;
        if (we_now) begin
            coef_we   = 1'b1;
            coef_addr = AW'(wa);
            coef_data = wd;
            h[wa] = longint'(wd);
        end
        model_push(x);
        exp = model_y();
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (we_mid && lat == 5) begin
                coef_we   = 1'b1;
                coef_addr = AW'(wa);
                coef_data = wd;
            end else begin
                coef_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        coef_we = 1'b0;
        check("latency", lat, NTAPS);
        if (out_valid) begin
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                in_data  = $urandom;
                @(negedge clk);
                check("bp_stable", out_data, held);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
            end
            in_valid = 1'b0;
            y = longint'($signed(out_data));
            check("y", $signed(out_data), exp);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("released_valid", out_valid, 0);
            check("released_ready", in_ready, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint y;
        int n;
        int n_out;
        int prev_acc;
        int last_acc;
        longint exp;
        logic signed [DW-1:0] x;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);

        // Impulse response with h[k] = k+1.
        for (int k = 0; k < NTAPS; k++) wcoef(k, CW'(k + 1));
        run_sample(32'sd32768, 0, 0, 0, 0, 0, y);
        check("imp_0", y, 1);
        for (int i = 1; i <= 20; i++) begin
            run_sample(0, 0, 0, 0, 0, 0, y);
            check("imp_n", y, (i < NTAPS) ? i + 1 : 0);
        end

        // Streaming: in_valid and out_ready held high, random coefficients.
        for (int k = 0; k < NTAPS; k++) wcoef(k, CW'($urandom));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        n_out = 0;
        prev_acc = -1;
        last_acc = 0;
        exp = 0;
        for (int c = 0; c < 120 && n_out < 4; c++) begin
            if (n == 4) in_valid = 1'b0;
            if (out_valid) begin
                check("tp_latency", cyc - last_acc, NTAPS);
                check("tp_y", $signed(out_data), exp);
                n_out++;
            end
            if (in_ready && n < 4) begin
                if (prev_acc >= 0) check("tp_period", cyc + 1 - prev_acc, NTAPS + 2);
                prev_acc = cyc + 1;
                last_acc = cyc + 1;
                x = $urandom;
                in_data = x;
                model_push(x);
                exp = model_y();
                n++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("tp_outputs", n_out, 4);
        @(negedge clk);

        // Backpressure for 10 cycles with in_valid asserted.
        run_sample($urandom, 10, 0, 0, 0, 0, y);

        // Coefficient write gating.
        wcoef(0, 16'sd5);
        run_sample(32'sd100000, 0, 0, 1, 0, 16'sd100, y);
        run_sample(32'sd200000, 0, 1, 0, 0, 16'sd100, y);

        // Saturation at both rails.
        for (int k = 0; k < NTAPS; k++) wcoef(k, 16'sd32767);
        for (int i = 0; i < NTAPS; i++) run_sample(32'sh7fffffff, 0, 0, 0, 0, 0, y);
        check("sat_hi", y, 64'sd2147483647);
        for (int k = 0; k < NTAPS; k++) wcoef(k, -16'sd32768);
        run_sample(32'sh7fffffff, 0, 0, 0, 0, 0, y);
        check("sat_lo", y, -64'sd2147483648);

        // Random coefficients, samples and backpressure.
        for (int k = 0; k < NTAPS; k++) wcoef(k, CW'($urandom));
        for (int i = 0; i < 8; i++) begin
            run_sample($urandom, $urandom_range(0, 3), 0, 0, 0, 0, y);
        end

        // Reset while the MAC is at k=7 aborts the computation.
        in_valid = 1'b1;
        in_data  = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        for (int k = 0; k < NTAPS; k++) wcoef(k, CW'(k + 1));
        run_sample(32'sd32768, 0, 0, 0, 0, 0, y);
        check("rimp_0", y, 1);
        for (int i = 1; i <= NTAPS; i++) begin
            run_sample(0, 0, 0, 0, 0, 0, y);
            check("rimp_n", y, (i < NTAPS) ? i + 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
